// File: rtl/serdes_pkg.sv
// Shared definitions for the serial link deserializer and the matching serializer.
package serdes_pkg;

  // Frame FSM states
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Bit-order selectors for the MSB_FIRST parameter
  localparam bit BIT_ORDER_MSB = 1'b1;
  localparam bit BIT_ORDER_LSB = 1'b0;

endpackage

// File: rtl/deser_shift_reg.sv
// Serial-in shift register. With clr the register restarts from a single
// bit (din) in the entry position, so an aborted frame leaves no residue.
module deser_shift_reg
  import serdes_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = BIT_ORDER_MSB
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_en,
  input  logic             clr,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_shifted;
  logic [WIDTH-1:0] w_fresh;

  generate
    if (MSB_FIRST) begin : g_msb
      // New bit enters at the LSB and moves up
      assign w_shifted = {r_q[WIDTH-2:0], din};
      assign w_fresh   = {{(WIDTH-1){1'b0}}, din};
    end else begin : g_lsb
      // New bit enters at the MSB and moves down
      assign w_shifted = {din, r_q[WIDTH-1:1]};
      assign w_fresh   = {din, {(WIDTH-1){1'b0}}};
    end
  endgenerate

  // Shift (or restart) on every accepted bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_q <= '0;
    else if (shift_en) r_q <= clr ? w_fresh : w_shifted;
  end

  assign q = r_q;

endmodule

// File: rtl/serial_deser.sv
// Bit-serial receive deserializer with a single-entry valid/ready output
// holding register and a sticky overrun flag for dropped frames.
module serial_deser
  import serdes_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = BIT_ORDER_MSB
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  input  logic             s_bit,
  input  logic             s_start,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             busy,
  output logic             overrun,
  input  logic             clr_overrun
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             w_shift_en, w_clr, w_complete;
  logic [WIDTH-1:0] w_q, w_word;
  logic [WIDTH-1:0] r_m_data;
  logic             r_m_valid, r_overrun, w_can_load;

  deser_shift_reg #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_sr (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (w_shift_en),
    .clr      (w_clr),
    .din      (s_bit),
    .q        (w_q)
  );

  // The finished word includes the bit arriving this cycle, so it is formed
  // here rather than waiting a cycle for the shift register to catch up.
  generate
    if (MSB_FIRST) begin : g_word_msb
      assign w_word = {w_q[WIDTH-2:0], s_bit};
    end else begin : g_word_lsb
      assign w_word = {s_bit, w_q[WIDTH-1:1]};
    end
  endgenerate

  // State and bit counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic: start restarts a frame from any state, gaps hold
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_en  = 1'b0;
    w_clr       = 1'b0;
    w_complete  = 1'b0;
    if (s_valid) begin
      if (s_start) begin
        w_shift_en  = 1'b1;
        w_clr       = 1'b1;
        w_cnt_nxt   = CW'(1);
        w_state_nxt = SHIFT;
      end else if (r_state == SHIFT) begin
        w_shift_en = 1'b1;
        if (r_cnt == LAST) begin
          w_complete  = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
    end
  end

  // A slot is free if empty or being drained on this same edge
  assign w_can_load = !r_m_valid || m_ready;

  // Output holding register: load on completion, drop on handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_data  <= '0;
      r_m_valid <= 1'b0;
    end else if (w_complete && w_can_load) begin
      r_m_data  <= w_word;
      r_m_valid <= 1'b1;
    end else if (r_m_valid && m_ready) begin
      r_m_valid <= 1'b0;
    end
  end

  // Sticky overrun: setting wins over a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      r_overrun <= 1'b0;
    else if (w_complete && !w_can_load) r_overrun <= 1'b1;
    else if (clr_overrun)            r_overrun <= 1'b0;
  end

  assign m_data  = r_m_data;
  assign m_valid = r_m_valid;
  assign overrun = r_overrun;
  assign busy    = (r_state == SHIFT);

endmodule
